// File: rtl/seg7_pkg.sv
// seg7_pkg: symbol codes and segment patterns for the 7-segment display path.
// Shared by the calculator's display encoder and the scan decoder.
//   sym_code_t     5-bit symbol code (0-15 hex digits, 16 minus, 17 blank, 31 invalid)
//   SEG_*          active-high gfedcba patterns (bit6 = g ... bit0 = a)
//   seg7_decode()  pattern -> symbol code, SYM_INVALID for anything unknown
package seg7_pkg;

  typedef logic [4:0] sym_code_t;

  localparam sym_code_t SYM_MINUS   = 5'd16;
  localparam sym_code_t SYM_BLANK   = 5'd17;
  localparam sym_code_t SYM_INVALID = 5'd31;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic sym_code_t seg7_decode(input logic [6:0] pat);
    sym_code_t code;
    case (pat)
      SEG_0:     code = 5'd0;
      SEG_1:     code = 5'd1;
      SEG_2:     code = 5'd2;
      SEG_3:     code = 5'd3;
      SEG_4:     code = 5'd4;
      SEG_5:     code = 5'd5;
      SEG_6:     code = 5'd6;
      SEG_7:     code = 5'd7;
      SEG_8:     code = 5'd8;
      SEG_9:     code = 5'd9;
      SEG_A:     code = 5'd10;
      SEG_B:     code = 5'd11;
      SEG_C:     code = 5'd12;
      SEG_D:     code = 5'd13;
      SEG_E:     code = 5'd14;
      SEG_F:     code = 5'd15;
      SEG_MINUS: code = SYM_MINUS;
      SEG_BLANK: code = SYM_BLANK;
      default:   code = SYM_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to symbol code.
//   pattern  in   7  active-high gfedcba
//   code     out  5  symbol code (SYM_INVALID for unknown patterns)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [4:0] code
);

  assign code = seg7_decode(pattern);

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: watches a multiplexed 7-segment scan, waits for each
// digit to settle, decodes it and publishes complete frames.
//   clk, rst_display   clock, synchronous active-high reset
//   seg_in[7:0]        dp,g,f,e,d,c,b,a (polarity set by ACTIVE_LOW)
//   digit_en_in[N-1:0] one-hot digit enable, digit 0 rightmost
//   frame_codes        symbol code of digit i in [5i+4:5i]
//   frame_dp           decimal point per digit, 1 = lit
//   frame_valid        1-cycle pulse, frame_codes/frame_dp just updated
//   frame_err          1-cycle pulse, frame discarded (missing digit or multi-drive)
// Handshake: frame_valid/frame_err are single-cycle strobes with no back-pressure;
// the published frame holds until the next frame_valid.
module seven_seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_display,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  output logic [5*NUM_DIGITS-1:0] frame_codes,
  output logic [NUM_DIGITS-1:0]   frame_dp,
  output logic                    frame_valid,
  output logic                    frame_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SMP_W = NUM_DIGITS + 8;
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [5*NUM_DIGITS-1:0] BLANK_CODES = {NUM_DIGITS{SYM_BLANK}};

  typedef enum logic {ST_SYNC, ST_ACQUIRE} state_t;

  // Sampling stage: normalised input register, previous sample, run length.
  logic [SMP_W-1:0] sample_d, sample_q, prev_d, prev_q;
  logic [7:0]       stab_cnt_d, stab_cnt_q;
  logic             cap_d, cap_q, same;

  // Frame assembly state.
  state_t                  state_d, state_q;
  logic [NUM_DIGITS-1:0]   seen_d, seen_q;
  logic [IDX_W-1:0]        last_k_d, last_k_q;
  logic [5*NUM_DIGITS-1:0] shadow_codes_d, shadow_codes_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_d, shadow_dp_q;
  logic [5*NUM_DIGITS-1:0] frame_codes_d, frame_codes_q;
  logic [NUM_DIGITS-1:0]   frame_dp_d, frame_dp_q;
  logic                    frame_valid_d, frame_valid_q;
  logic                    frame_err_d, frame_err_q;

  // Captured digit (prev_q holds the sample that completed the stable run).
  logic [NUM_DIGITS-1:0] cap_en;
  logic [7:0]            cap_seg;
  logic [4:0]            cap_code;
  logic [IDX_W-1:0]      cap_k;
  logic                  cap_any, cap_multi, start_frame;

  assign cap_en  = prev_q[SMP_W-1:8];
  assign cap_seg = prev_q[7:0];

  seg7_pattern_decode u_decode (
    .pattern (cap_seg[6:0]),
    .code    (cap_code)
  );

  always_comb begin
    sample_d   = ACTIVE_LOW ? ~{digit_en_in, seg_in} : {digit_en_in, seg_in};
    prev_d     = sample_q;
    same       = (sample_q == prev_q);
    stab_cnt_d = 8'd1;
    if (same) stab_cnt_d = (stab_cnt_q == STAB_MAX) ? STAB_MAX : stab_cnt_q + 8'd1;
    // One capture per stable run: only on the cycle the count first hits the limit.
    cap_d = (stab_cnt_d == STAB_MAX) && !(same && (stab_cnt_q == STAB_MAX));
  end

  always_comb begin
    cap_any   = |cap_en;
    cap_multi = (cap_en & (cap_en - 1'b1)) != '0;
    cap_k     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_en[i]) cap_k = IDX_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    seen_d         = seen_q;
    last_k_d       = last_k_q;
    shadow_codes_d = shadow_codes_q;
    shadow_dp_d    = shadow_dp_q;
    frame_codes_d  = frame_codes_q;
    frame_dp_d     = frame_dp_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    start_frame    = 1'b0;

    if (cap_q && cap_any) begin
      if (cap_multi) begin
        // Ghosting while synced throws the frame away; while hunting it is ignored.
        if (state_q == ST_ACQUIRE) begin
          frame_err_d = 1'b1;
          seen_d      = '0;
          state_d     = ST_SYNC;
        end
      end else if (state_q == ST_SYNC) begin
        start_frame = (cap_k == '0);
      end else if (cap_k > last_k_q) begin
        shadow_codes_d[5*int'(cap_k) +: 5] = cap_code;
        shadow_dp_d[cap_k]                 = cap_seg[7];
        seen_d[cap_k]                      = 1'b1;
        last_k_d                           = cap_k;
      end else begin
        // Index went backwards: the scan wrapped, so the previous frame is closed.
        if (&seen_q) begin
          frame_valid_d = 1'b1;
          frame_codes_d = shadow_codes_q;
          frame_dp_d    = shadow_dp_q;
        end else begin
          frame_err_d = 1'b1;
        end
        seen_d = '0;
        if (cap_k == '0) start_frame = 1'b1;
        else             state_d     = ST_SYNC;
      end

      if (start_frame) begin
        shadow_codes_d[4:0] = cap_code;
        shadow_dp_d[0]      = cap_seg[7];
        seen_d              = NUM_DIGITS'(1);
        last_k_d            = '0;
        state_d             = ST_ACQUIRE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_display) begin
      sample_q       <= '0;
      prev_q         <= '0;
      stab_cnt_q     <= '0;
      cap_q          <= 1'b0;
      state_q        <= ST_SYNC;
      seen_q         <= '0;
      last_k_q       <= '0;
      shadow_codes_q <= '0;
      shadow_dp_q    <= '0;
      frame_codes_q  <= BLANK_CODES;
      frame_dp_q     <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      prev_q         <= prev_d;
      stab_cnt_q     <= stab_cnt_d;
      cap_q          <= cap_d;
      state_q        <= state_d;
      seen_q         <= seen_d;
      last_k_q       <= last_k_d;
      shadow_codes_q <= shadow_codes_d;
      shadow_dp_q    <= shadow_dp_d;
      frame_codes_q  <= frame_codes_d;
      frame_dp_q     <= frame_dp_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign frame_codes = frame_codes_q;
  assign frame_dp    = frame_dp_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
